spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 64, meaning the maximum number of clk cycles to wait for reg_ack per bus access.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hEE, meaning the byte returned to the master on a read timeout.
REQ-003 clk  input  1  main clock (min 50 MHz), rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  debounced chip-select level from the byte shifter front end; 1 = deselected.
REQ-006 rx_byte  input  8  last received byte from the shifter.
REQ-007 rx_flag  input  1  shifter "byte received" level flag.
REQ-008 tx_end_flag  input  1  shifter "byte transmitted" level flag.
REQ-009 trans_flag  output  1  selects shifter transmit mode; 0 = receive.
REQ-010 tx_byte  output  8  byte the shifter sends, MSB first.
REQ-011 reg_addr  output  7  register address.
REQ-012 reg_wdata  output  8  register write data.
REQ-013 reg_wr / reg_rd  output  1 each  single-cycle-held bus strobes, held until ack or timeout.
REQ-014 reg_rdata  input  8  read data, valid with reg_ack.
REQ-015 reg_ack  input  1  bus acknowledge, one cycle.
REQ-016 err  output  1  sticky timeout flag, cleared when cs rises.

Function
REQ-017 Frame = cs low; byte 0 = command {rw, addr[6:0]}, with rw = 1 meaning read; subsequent bytes = data.
REQ-018 rx_flag and tx_end_flag are levels; the block SHALL act only on their 0->1 transitions, registered one cycle.
REQ-019 States: IDLE, CMD, WDATA, WBUS, RBUS, TX, DONE.
REQ-020 IDLE->CMD on cs falling; while in CMD, trans_flag=0.
REQ-021 CMD, rx edge, rw=0: latch addr, ->WDATA. rx edge, rw=1: latch addr, assert reg_rd, ->RBUS.
REQ-022 WDATA, rx edge: reg_wdata<=rx_byte, assert reg_wr, ->WBUS.
REQ-023 WBUS: on reg_ack, drop reg_wr, advance per REQ-035/036.
REQ-024 RBUS: on reg_ack, tx_byte<=reg_rdata, trans_flag<=1, ->TX; reg_rd drops the same cycle.
REQ-025 TX, tx_end edge: advance per REQ-035/036; in the burst case, re-issue reg_rd at the next address and ->RBUS with trans_flag held at 1.
REQ-026 Read latency, rx edge to trans_flag=1: ack latency + 2 clk cycles; the master SHALL leave at least ACK_TIMEOUT+4 clk cycles of gap before the data byte.
REQ-027 Timeout: a cycle counter runs in WBUS/RBUS; when it reaches ACK_TIMEOUT with no ack: drop strobe, set err=1; if in RBUS, tx_byte<=ERR_BYTE, then proceed as if acked.
REQ-028 reg_ack outside WBUS/RBUS SHALL be ignored.
REQ-029 DONE: ignore all flags, trans_flag=0, until cs rises.
REQ-030 cs rise in any state: strobes drop immediately (same cycle, combinational gating); ->IDLE next clk; trans_flag=0; err=0; a pending bus access is abandoned.
REQ-031 cs rise coincident with reg_ack: the ack is discarded; write data is not guaranteed committed.
REQ-032 Never reg_wr and reg_rd simultaneously; one outstanding access max.

Reset
REQ-033 rst=1: state=IDLE, trans_flag=0, tx_byte=8'h00, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, err=0, edge registers=0, counter=0.
REQ-034 rst mid-frame SHALL take effect asynchronously; after release the block stays in IDLE until a new cs falling edge.

Configuration
REQ-035 Macro SPI_REG_CTRL_BURST_EN defined: after each data byte, addr<=addr+1 (wraps 7'h7F->7'h00) and the block returns to WDATA (write) or RBUS (read) until cs rises.
REQ-036 Macro undefined: after one data byte, ->DONE; addr never increments.

Verification
REQ-037 Write: cs low, bytes 0x05, 0xA5 -> one reg_wr with addr 0x05, wdata 0xA5; ack after 3 cycles -> reg_wr lasts 3 cycles, err=0.
REQ-038 Read: byte 0x85, rdata 0x3C acked after 5 cycles -> trans_flag=1 and tx_byte=0x3C by 7 cycles after the rx edge; master shifts in 0x3C.
REQ-039 Timeout: read 0x81, never ack -> reg_rd drops after 64 cycles, err=1, tx_byte=0xEE; cs high -> err=0.
REQ-040 Burst (BURST_EN): write cmd 0x7F, data 0x11, 0x22 -> writes addr 0x7F=0x11, then 0x00=0x22; without the macro, only 0x7F=0x11 occurs and the second byte is ignored.
REQ-041 Abort: cs rises during WBUS before ack -> reg_wr=0 the same cycle, IDLE next cycle; rst asserted mid-read -> all outputs at reset values.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI register-bus bridge: byte 0 = {rw, addr[6:0]}, then data bytes; burst addressing when SPI_REG_CTRL_BURST_EN is defined.
// Latency: rx edge registered one cycle; read data reaches tx_byte/trans_flag ack latency + 2 cycles after the rx edge.
// Backpressure: strobes hold until reg_ack or ACK_TIMEOUT cycles; cs high drops strobes combinationally and abandons the access.
`timescale 1ns/1ps
module spi_reg_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [7:0] rx_byte,
    input  logic       rx_flag,
    input  logic       tx_end_flag,
    output logic       trans_flag,
    output logic [7:0] tx_byte,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WBUS,
        S_RBUS,
        S_TX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trans_flag_q, trans_flag_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [6:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       reg_wdata_q, reg_wdata_d;
    logic             reg_wr_q, reg_wr_d;
    logic             reg_rd_q, reg_rd_d;
    logic             err_q, err_d;
    logic             rx_prev_q, rx_prev_d;
    logic             rx_edge_q, rx_edge_d;
    logic             tx_prev_q, tx_prev_d;
    logic             tx_edge_q, tx_edge_d;
    logic             cs_prev_q, cs_prev_d;
    logic             bus_timeout;

    // Next-state logic: edge detection, frame FSM, bus timeout counter
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trans_flag_d = trans_flag_q;
        tx_byte_d    = tx_byte_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_wr_d     = reg_wr_q;
        reg_rd_d     = reg_rd_q;
        err_d        = err_q;
        rx_prev_d    = rx_flag;
        rx_edge_d    = rx_flag & ~rx_prev_q;
        tx_prev_d    = tx_end_flag;
        tx_edge_d    = tx_end_flag & ~tx_prev_q;
        cs_prev_d    = cs;
        bus_timeout  = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

        if (cs) begin
            // Deselected: abandon any access, any pending ack is discarded
            state_d      = S_IDLE;
            cnt_d        = '0;
            trans_flag_d = 1'b0;
            reg_wr_d     = 1'b0;
            reg_rd_d     = 1'b0;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // cs was high last cycle and is low now: frame start
                    if (cs_prev_q) begin
                        state_d      = S_CMD;
                        trans_flag_d = 1'b0;
                    end
                end
                S_CMD: begin
                    trans_flag_d = 1'b0;
                    if (rx_edge_q) begin
                        reg_addr_d = rx_byte[6:0];
                        if (rx_byte[7]) begin
                            reg_rd_d = 1'b1;
                            cnt_d    = '0;
                            state_d  = S_RBUS;
                        end else begin
                            state_d  = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_edge_q) begin
                        reg_wdata_d = rx_byte;
                        reg_wr_d    = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_WBUS;
                    end
                end
                S_WBUS: begin
                    if (reg_ack || bus_timeout) begin
                        reg_wr_d = 1'b0;
                        cnt_d    = '0;
                        if (!reg_ack) begin
                            err_d = 1'b1;
                        end
`ifdef SPI_REG_CTRL_BURST_EN
                        reg_addr_d = reg_addr_q + 7'd1;
                        state_d    = S_WDATA;
`else
                        state_d    = S_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RBUS: begin
                    if (reg_ack || bus_timeout) begin
                        reg_rd_d     = 1'b0;
                        cnt_d        = '0;
                        trans_flag_d = 1'b1;
                        state_d      = S_TX;
                        if (reg_ack) begin
                            tx_byte_d = reg_rdata;
                        end else begin
                            tx_byte_d = ERR_BYTE;
                            err_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_TX: begin
                    if (tx_edge_q) begin
`ifdef SPI_REG_CTRL_BURST_EN
                        // Prefetch the next address; trans_flag stays high
                        reg_addr_d = reg_addr_q + 7'd1;
                        reg_rd_d   = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_RBUS;
`else
                        trans_flag_d = 1'b0;
                        state_d      = S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    trans_flag_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            trans_flag_q <= 1'b0;
            tx_byte_q    <= 8'h00;
            reg_addr_q   <= 7'h00;
            reg_wdata_q  <= 8'h00;
            reg_wr_q     <= 1'b0;
            reg_rd_q     <= 1'b0;
            err_q        <= 1'b0;
            rx_prev_q    <= 1'b0;
            rx_edge_q    <= 1'b0;
            tx_prev_q    <= 1'b0;
            tx_edge_q    <= 1'b0;
            cs_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trans_flag_q <= trans_flag_d;
            tx_byte_q    <= tx_byte_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_wr_q     <= reg_wr_d;
            reg_rd_q     <= reg_rd_d;
            err_q        <= err_d;
            rx_prev_q    <= rx_prev_d;
            rx_edge_q    <= rx_edge_d;
            tx_prev_q    <= tx_prev_d;
            tx_edge_q    <= tx_edge_d;
            cs_prev_q    <= cs_prev_d;
        end
    end

    // cs high kills strobes and transmit mode in the same cycle
    assign reg_wr     = reg_wr_q & ~cs;
    assign reg_rd     = reg_rd_q & ~cs;
    assign trans_flag = trans_flag_q & ~cs;
    assign tx_byte    = tx_byte_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frames, randomized read/write frames, abort and mid-frame reset.
// A bus responder acks after a chosen strobe length (0 = never) and logs every access.
// Expected accesses, bytes and flags come from a frame-level model of the protocol.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;

    localparam int TMO = 64;
`ifdef SPI_REG_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic [7:0] rx_byte;
    logic       rx_flag;
    logic       tx_end_flag;
    logic       trans_flag;
    logic [7:0] tx_byte;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       err;

    spi_reg_ctrl #(.ACK_TIMEOUT(TMO), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rx_byte(rx_byte), .rx_flag(rx_flag),
        .tx_end_flag(tx_end_flag), .trans_flag(trans_flag), .tx_byte(tx_byte),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus responder and access log
    int         ack_delay  = 1;
    logic [7:0] rdata_base = 8'h00;
    int         q_wr[$];
    int         q_addr[$];
    int         q_wdata[$];
    int         q_dur[$];
    int         both_seen  = 0;
    bit         in_acc     = 1'b0;
    int         dur        = 0;

    initial begin
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            reg_ack = 1'b0;
            if (reg_wr && reg_rd) both_seen++;
            if (reg_wr || reg_rd) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    dur    = 0;
                    q_wr.push_back(int'(reg_wr));
                    q_addr.push_back(int'(reg_addr));
                    q_wdata.push_back(int'(reg_wdata));
                end
                dur++;
                if (dur == ack_delay) begin
                    reg_ack   = 1'b1;
                    reg_rdata = rdata_base + {1'b0, reg_addr};
                end
            end else if (in_acc) begin
                in_acc = 1'b0;
                q_dur.push_back(dur);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_flag = 1'b1;
        cyc(2);
        rx_flag = 1'b0;
        cyc(1);
    endtask

    function automatic int gap();
        return (ack_delay == 0) ? TMO + 8 : ack_delay + 6;
    endfunction

    // Strobe length: ack delay, or the full timeout window when never acked
    function automatic int exp_dur();
        return (ack_delay == 0) ? TMO : ack_delay;
    endfunction

    task automatic do_write(input logic [6:0] a, input logic [7:0] d[3], input int n, input int delay);
        int base;
        int nexp;
        base      = q_wr.size();
        ack_delay = delay;
        cs = 1'b0;
        cyc(2);
        send_byte({1'b0, a});
        cyc(2);
        for (int i = 0; i < n; i++) begin
            send_byte(d[i]);
            cyc(gap());
        end
        chk("wr_err", err, (delay == 0));
        cs = 1'b1;
        cyc(2);
        chk("wr_err_clr", err, 0);
        nexp = BURST ? n : 1;
        chk("wr_count", q_wr.size() - base, nexp);
        for (int i = 0; i < nexp && base + i < q_wr.size(); i++) begin
            chk("wr_kind", q_wr[base + i], 1);
            chk("wr_addr", q_addr[base + i], (int'(a) + i) % 128);
            chk("wr_data", q_wdata[base + i], d[i]);
            chk("wr_dur", q_dur[base + i], exp_dur());
        end
    endtask

    task automatic do_read(input logic [6:0] a, input int n, input int delay, input logic [7:0] rb);
        int         base;
        int         nexp;
        int         lat;
        int         k;
        bit         seen;
        logic [7:0] exp_b;
        base       = q_wr.size();
        ack_delay  = delay;
        rdata_base = rb;
        cs = 1'b0;
        cyc(2);
        rx_byte = {1'b1, a};
        rx_flag = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (lat < TMO + 10 && !seen) begin
            cyc(1);
            lat++;
            if (lat == 2) rx_flag = 1'b0;
            if (trans_flag) seen = 1'b1;
        end
        rx_flag = 1'b0;
        chk("rd_trans_seen", seen, 1);
        chk("rd_latency_ok", (lat <= exp_dur() + 2), 1);
        for (int i = 0; i < n; i++) begin
            cyc((i == 0) ? 0 : gap());
            k     = BURST ? i : 0;
            exp_b = (delay == 0) ? 8'hEE : 8'(int'(rb) + (int'(a) + k) % 128);
            chk("rd_tx_byte", tx_byte, exp_b);
            chk("rd_trans_on", trans_flag, (BURST || i == 0));
            tx_end_flag = 1'b1;
            cyc(2);
            tx_end_flag = 1'b0;
            cyc(1);
        end
        cyc(gap());
        chk("rd_trans_end", trans_flag, BURST);
        chk("rd_err", err, (delay == 0));
        cs = 1'b1;
        cyc(2);
        chk("rd_err_clr", err, 0);
        chk("rd_trans_clr", trans_flag, 0);
        nexp = BURST ? n + 1 : 1;
        chk("rd_count", q_wr.size() - base, nexp);
        for (int i = 0; i < nexp && base + i < q_wr.size(); i++) begin
            chk("rd_kind", q_wr[base + i], 0);
            chk("rd_addr", q_addr[base + i], (int'(a) + i) % 128);
            chk("rd_dur", q_dur[base + i], exp_dur());
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trans"}, trans_flag, 0);
        chk({tag, "_tx_byte"}, tx_byte, 8'h00);
        chk({tag, "_addr"}, reg_addr, 7'h00);
        chk({tag, "_wdata"}, reg_wdata, 8'h00);
        chk({tag, "_wr"}, reg_wr, 0);
        chk({tag, "_rd"}, reg_rd, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wd[3];
        int         base;
        int         dly;
        rst         = 1'b1;
        cs          = 1'b1;
        rx_byte     = 8'h00;
        rx_flag     = 1'b0;
        tx_end_flag = 1'b0;
        cyc(2);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(2);

        // Directed frames
        wd = '{8'hA5, 8'h00, 8'h00};
        do_write(7'h05, wd, 1, 3);
        do_read(7'h05, 1, 5, 8'h37);
        do_read(7'h01, 1, 0, 8'h00);
        wd = '{8'h11, 8'h22, 8'h00};
        do_write(7'h7F, wd, 2, 2);

        // Randomized frames
        for (int f = 0; f < 16; f++) begin
            dly = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 1) begin
                for (int j = 0; j < 3; j++) wd[j] = 8'($urandom);
                do_write(7'($urandom), wd, int'($urandom_range(1, 3)), dly);
            end else begin
                do_read(7'($urandom), int'($urandom_range(1, 2)), dly, 8'($urandom));
            end
        end

        // Abort during a write bus access
        ack_delay = 0;
        cs = 1'b0;
        cyc(2);
        send_byte(8'h10);
        cyc(2);
        send_byte(8'h55);
        cyc(2);
        chk("abort_wr_pre", reg_wr, 1);
        cs = 1'b1;
        #1;
        chk("abort_wr_gate", reg_wr, 0);
        cyc(2);
        chk("abort_err", err, 0);
        wd = '{8'h66, 8'h00, 8'h00};
        do_write(7'h22, wd, 1, 4);

        // Asynchronous reset in the middle of a read
        ack_delay = 0;
        cs = 1'b0;
        cyc(2);
        send_byte(8'hA0);
        cyc(2);
        chk("rst_rd_pre", reg_rd, 1);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        cyc(2);
        rst = 1'b0;
        cyc(2);
        base = q_wr.size();
        send_byte(8'h81);
        cyc(10);
        chk("rst_idle_count", q_wr.size() - base, 0);
        chk("rst_idle_trans", trans_flag, 0);
        cs = 1'b1;
        cyc(2);
        do_read(7'h33, 1, 2, 8'h40);

        chk("never_both_strobes", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
